c3lib_rst_seq: RTL and testbench

Reset sequencer that drives the `rst_n` of the c3lib flop primitives in one clock domain. Reset assertion passes through asynchronously. Deassertion is synchronized to `clk` and held off by a programmable number of cycles. An optional software reset request, using a four-phase handshake, can re-pulse the domain reset. One instance sits at the root of each clock domain's reset tree, directly upstream of every `c3lib_dff*_reset` flop in that domain.

---
 rtl/c3lib_rst_seq_pkg.sv | 32 +++
 rtl/c3lib_rst_sync_chain.sv | 23 ++
 rtl/c3lib_rst_seq.sv | 109 ++++++++++
 tb/tb_c3lib_rst_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_rst_seq_pkg.sv
// c3lib_rst_seq_pkg: state encoding and parameter legal ranges for the reset sequencer.
// Optional soft reset states are compiled in with C3LIB_RST_SEQ_SOFT_RST_EN.
package c3lib_rst_seq_pkg;

    localparam int SYNC_STAGES_MIN      = 2;
    localparam int SYNC_STAGES_MAX      = 4;
    localparam int DEASSERT_CYCLES_MIN  = 1;
    localparam int DEASSERT_CYCLES_MAX  = 255;
    localparam int SOFT_HOLD_CYCLES_MIN = 1;
    localparam int SOFT_HOLD_CYCLES_MAX = 255;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_COUNT = 3'd1,
        ST_RUN   = 3'd2
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
        ,
        ST_SOFT  = 3'd3,
        ST_ACK   = 3'd4
`endif
    } rst_seq_state_e;

    // States in which the domain is out of reset.
    function automatic logic is_live(input rst_seq_state_e s);
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
        return s == ST_RUN || s == ST_ACK;
`else
        return s == ST_RUN;
`endif
    endfunction

endpackage

// File: rtl/c3lib_rst_sync_chain.sv
// c3lib_rst_sync_chain: reset-deassert synchronizer, STAGES flops async-cleared by rst_n, input tied high.
// Flops carry a don't-touch attribute when USER_MACROS_ON is defined.
module c3lib_rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_out
);

`ifdef USER_MACROS_ON
    (* dont_touch = "true" *)
`endif
    logic [STAGES-1:0] q;

    // Shift a constant one through the chain once reset is released.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= {q[STAGES-2:0], 1'b1};

    assign sync_out = q[STAGES-1];

endmodule

// File: rtl/c3lib_rst_seq.sv
// c3lib_rst_seq: per-domain reset sequencer, async assert / sync deassert with programmable hold-off.
// Defining C3LIB_RST_SEQ_SOFT_RST_EN adds the soft_rst_req/soft_rst_ack four-phase soft reset.
module c3lib_rst_seq
    import c3lib_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEASSERT_CYCLES  = 16,
    parameter int SOFT_HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
    input  logic soft_rst_req,
    output logic soft_rst_ack,
`endif
    output logic rst_n_out,
    output logic rst_done
);

    localparam int CNT_MAX = (DEASSERT_CYCLES > SOFT_HOLD_CYCLES) ? DEASSERT_CYCLES : SOFT_HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT       = CW'(CNT_MAX);
    localparam logic [CW-1:0] DEASSERT_LAST = CW'(DEASSERT_CYCLES - 1);
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
    localparam logic [CW-1:0] SOFT_LAST     = CW'(SOFT_HOLD_CYCLES);
`endif

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("c3lib_rst_seq: SYNC_STAGES %0d out of range", SYNC_STAGES);
    end
    if (DEASSERT_CYCLES < DEASSERT_CYCLES_MIN || DEASSERT_CYCLES > DEASSERT_CYCLES_MAX) begin : g_bad_deassert
        $error("c3lib_rst_seq: DEASSERT_CYCLES %0d out of range", DEASSERT_CYCLES);
    end
    if (SOFT_HOLD_CYCLES < SOFT_HOLD_CYCLES_MIN || SOFT_HOLD_CYCLES > SOFT_HOLD_CYCLES_MAX) begin : g_bad_soft
        $error("c3lib_rst_seq: SOFT_HOLD_CYCLES %0d out of range", SOFT_HOLD_CYCLES);
    end

    rst_seq_state_e state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           counting;
    logic           sync_done;
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
    logic           soft_pend, soft_pend_next;
`endif

    c3lib_rst_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_out (sync_done)
    );

    // Next state; the counter runs only while staying in a timed state and clears on every transition.
    always_comb begin
        state_next = state;
        counting   = 1'b0;
        case (state)
            ST_RESET: state_next = sync_done ? ST_COUNT : ST_RESET;
            ST_COUNT: begin
                counting = 1'b1;
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
                if (cnt == DEASSERT_LAST) state_next = soft_pend ? ST_ACK : ST_RUN;
`else
                if (cnt == DEASSERT_LAST) state_next = ST_RUN;
`endif
            end
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
            ST_RUN:   state_next = soft_rst_req ? ST_SOFT : ST_RUN;
            ST_SOFT: begin
                counting = 1'b1;
                if (cnt == SOFT_LAST) state_next = ST_COUNT;
            end
            ST_ACK:   state_next = soft_rst_req ? ST_ACK : ST_RUN;
`else
            ST_RUN:   state_next = ST_RUN;
`endif
            default:  state_next = ST_RESET;
        endcase
        cnt_next = (counting && state_next == state) ? ((cnt == CNT_SAT) ? cnt : cnt + CW'(1)) : '0;
    end

    // State, counter and registered outputs; rst_done needs a full live cycle before rising.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= ST_RESET;
            cnt       <= '0;
            rst_n_out <= 1'b0;
            rst_done  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rst_n_out <= is_live(state_next);
            rst_done  <= is_live(state_next) && is_live(state);
        end

`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
    assign soft_pend_next = (state_next == ST_SOFT) || (soft_pend && state_next != ST_ACK);

    // Remember that the current deassert sequence came from a soft request, and drive the acknowledge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            soft_pend    <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            soft_pend    <= soft_pend_next;
            soft_rst_ack <= state_next == ST_ACK;
        end
`endif

endmodule

// File: tb/tb_c3lib_rst_seq.sv
// tb_c3lib_rst_seq: randomized bench for c3lib_rst_seq against an edge-timestamp model.
// Soft reset scenarios are exercised when C3LIB_RST_SEQ_SOFT_RST_EN is defined.
module tb_c3lib_rst_seq;

    localparam int S = 2;
    localparam int D = 16;
    localparam int H = 8;
    localparam int PERIOD = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic rst_n_out, rst_done, f_out, f_done;
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
    logic ack, f_ack;
`endif

    always #(PERIOD / 2) clk = ~clk;

    c3lib_rst_seq #(.SYNC_STAGES(S), .DEASSERT_CYCLES(D), .SOFT_HOLD_CYCLES(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
        .soft_rst_req (req),
        .soft_rst_ack (ack),
`endif
        .rst_n_out    (rst_n_out),
        .rst_done     (rst_done)
    );

    c3lib_rst_seq #(.SYNC_STAGES(4), .DEASSERT_CYCLES(1), .SOFT_HOLD_CYCLES(1)) dut_fast (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
        .soft_rst_req (1'b0),
        .soft_rst_ack (f_ack),
`endif
        .rst_n_out    (f_out),
        .rst_done     (f_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int edge_no, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, edge_no, act, exp);
        end
    endtask

    // Model: the domain comes out of reset on a known edge number (up); everything else follows from it.
    int e = 0;
    int up = 0;
    int rst_falls = 0;
    int seen_falls = 0;
    bit in_rst = 1'b1;
    bit x_out = 1'b0, x_done = 1'b0, x_ack = 1'b0, soft_pend = 1'b0, ack_wait = 1'b0;

    always @(negedge rst_n) rst_falls++;

    always @(posedge clk) begin : model
        bit prev, was_wait;
        e++;
        prev = x_out;
        was_wait = ack_wait;
        if (!rst_n) begin
            in_rst = 1'b1;
            {x_out, x_done, x_ack, soft_pend, ack_wait} = '0;
        end else if (in_rst || rst_falls != seen_falls) begin
            in_rst = 1'b0;
            {x_out, x_done, x_ack, soft_pend, ack_wait} = '0;
            up = e + S + D;
        end else begin
            if (ack_wait && !req) begin
                ack_wait = 1'b0;
                x_ack = 1'b0;
            end
            if (prev && !was_wait && req) begin
                x_out = 1'b0;
                soft_pend = 1'b1;
                up = e + H + D + 1;
            end else if (e == up) begin
                x_out = 1'b1;
                if (soft_pend) begin
                    soft_pend = 1'b0;
                    ack_wait = 1'b1;
                    x_ack = 1'b1;
                end
            end
            x_done = prev && x_out;
        end
        seen_falls = rst_falls;
    end

    // Hand-computed expectations keyed by edge number; they pin both the DUT and the model.
    bit pin_out[int];
    bit pin_done[int];
    bit pin_ack[int];
    bit pin_fout[int];
    bit pin_fdone[int];

    // Single compare process: every falling clock edge, plus immediately after any rst_n fall.
    initial begin : compare
        time t;
        forever begin
            @(negedge clk or negedge rst_n);
            t = $time;
            #1;
            if (t % PERIOD != 0) begin
                chk("async_out", e, rst_n_out, 1'b0);
                chk("async_done", e, rst_done, 1'b0);
                chk("async_fast_out", e, f_out, 1'b0);
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
                chk("async_ack", e, ack, 1'b0);
`endif
            end else begin
                chk("out", e, rst_n_out, x_out);
                chk("done", e, rst_done, x_done);
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
                chk("ack", e, ack, x_ack);
                if (pin_ack.exists(e)) begin
                    chk("pin_ack", e, ack, pin_ack[e]);
                    chk("model_ack", e, x_ack, pin_ack[e]);
                end
`endif
                if (pin_out.exists(e)) begin
                    chk("pin_out", e, rst_n_out, pin_out[e]);
                    chk("model_out", e, x_out, pin_out[e]);
                end
                if (pin_done.exists(e)) begin
                    chk("pin_done", e, rst_done, pin_done[e]);
                    chk("model_done", e, x_done, pin_done[e]);
                end
                if (pin_fout.exists(e)) chk("pin_fast_out", e, f_out, pin_fout[e]);
                if (pin_fdone.exists(e)) chk("pin_fast_done", e, f_done, pin_fdone[e]);
            end
        end
    end

    task automatic wait_e(input int n);
        while (e < n) @(negedge clk);
        #4;
    endtask

    initial begin : stim
        int base, r;
        pin_out[1] = 1'b0; pin_done[1] = 1'b0;
        pin_out[18] = 1'b0; pin_out[19] = 1'b1;
        pin_done[19] = 1'b0; pin_done[20] = 1'b1;
        pin_fout[5] = 1'b0; pin_fout[6] = 1'b1;
        pin_fdone[6] = 1'b0; pin_fdone[7] = 1'b1;
        #4 rst_n = 1'b1;
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
        pin_out[50] = 1'b0; pin_done[50] = 1'b0; pin_out[74] = 1'b0; pin_ack[74] = 1'b0;
        pin_out[75] = 1'b1; pin_ack[75] = 1'b1; pin_done[75] = 1'b0; pin_done[76] = 1'b1;
        pin_ack[79] = 1'b1; pin_ack[80] = 1'b0;
        wait_e(49); req = 1'b1;
        wait_e(79); req = 1'b0;
        pin_out[140] = 1'b1; pin_ack[140] = 1'b1; pin_ack[151] = 1'b0; pin_out[156] = 1'b0;
        pin_out[180] = 1'b0; pin_out[181] = 1'b1; pin_ack[181] = 1'b1; pin_ack[182] = 1'b0;
        wait_e(85); req = 1'b1;
        wait_e(150); req = 1'b0;
        wait_e(155); req = 1'b1;
        wait_e(160); req = 1'b0;
        pin_out[215] = 1'b0; pin_out[216] = 1'b1; pin_ack[216] = 1'b0; pin_done[217] = 1'b1;
        wait_e(190); req = 1'b1;
        wait_e(195); rst_n = 1'b0; req = 1'b0;
        wait_e(197); rst_n = 1'b1;
        base = 230;
`else
        base = 40;
`endif
        pin_out[base] = 1'b1;
        pin_out[base + 18] = 1'b0;
        pin_out[base + 19] = 1'b1;
        pin_done[base + 19] = 1'b0;
        pin_done[base + 20] = 1'b1;
        wait_e(base);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        wait_e(base + 25);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            #4;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end else if (r == 1) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #4 rst_n = 1'b1;
            end
`ifdef C3LIB_RST_SEQ_SOFT_RST_EN
            else if (r < 16) req = ~req;
`endif
        end
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
